issue_queue_fifo: RTL and testbench
===================================

// Module: issue_queue_fifo
// PURPOSE
//  In-order issue queue sitting directly downstream of the decoder.
//  Buffers decoded ISSUE_QUEUE_ELEMENT entries and hands them to the execute stage.
//  Uses a valid/ready handshake on both sides.
//  A flush (branch mispredict / redirect) discards every buffered entry.
// PARAMETERS
//  DEPTH   8                 number of entries; legal range DEPTH >= 2, need not be a power of two
//  PTR_W   $clog2(DEPTH)     head/tail pointer width (derived, not overridden)
// PORTS
//  clk        in   1                     single clock; all state on rising edge
//  rst        in   1                     synchronous, active-high reset
//  flush      in   1                     discard all entries this cycle
//  enq_valid  in   1                     decoder presents enq_elem
//  enq_ready  out  1                     queue can accept an entry this cycle
//  enq_elem   in   ISSUE_QUEUE_ELEMENT   decoded instruction from decoder
//  deq_valid  out  1                     deq_elem holds the oldest entry
//  deq_ready  in   1                     execute stage takes deq_elem this cycle
//  deq_elem   out  ISSUE_QUEUE_ELEMENT   oldest buffered entry
//  count      out  PTR_W+1               number of valid entries (0..DEPTH)
// BEHAVIOUR
//  Reset (rst=1 at a clock edge):
//   - head=0, tail=0, count=0.
//   - Outputs next cycle: enq_ready=1, deq_valid=0, deq_elem='0.
//   - Storage array is not reset.
//  Handshake:
//   - enq_fire = enq_valid & enq_ready & ~flush.
//   - deq_fire = deq_valid & deq_ready.
//   - enq_ready = (count != DEPTH). It has no combinational dependence on deq_ready.
//     A full queue therefore refuses enqueue even when a dequeue fires in the same cycle.
//   - deq_valid = (count != 0) & ~flush.
//   - deq_elem = mem[head] when count != 0, else '0. It is read from storage only,
//     never bypassed from enq_elem.
//  Latency:
//   - An entry enqueued in cycle N is visible on deq_valid/deq_elem in cycle N+1.
//   - No same-cycle fall-through.
//  Enqueue:
//   - On enq_fire, mem[tail] <= enq_elem and tail advances by one.
//   - Wrap: tail == DEPTH-1 advances to 0. Same rule for head.
//  Dequeue:
//   - On deq_fire, head advances by one.
//   - The element fields are passed through unchanged, including
//     predict_pc_addr and predict_brunch_taken.
//  Count:
//   - count_next = count + enq_fire - deq_fire.
//   - Simultaneous enq_fire & deq_fire leaves count unchanged; both pointers advance.
//  Flush (flush=1 at a clock edge, rst=0):
//   - head, tail and count return to 0. Any enqueue in that cycle is dropped.
//   - deq_valid is forced 0 during the flush cycle, so no dequeue can fire.
//   - Flush has priority over enq/deq. rst has priority over flush.
//  Boundaries:
//   - Empty: deq_ready is ignored. Full: enq_valid is ignored; the decoder must hold enq_elem.
//   - Reset or flush asserted mid-stream loses all entries. There is no partial drain.
//  Assertions (sim only):
//   - count <= DEPTH.
//   - No enq_fire while count == DEPTH.
//   - No deq_fire while count == 0.
// STRUCTURE
//  - Shared package/defines.svh: ISSUE_QUEUE_ELEMENT (existing typedef) and a new
//    constant ISSUE_QUEUE_DEPTH (default 8) used as the DEPTH override at instantiation.
//  - No sub-module is required. Pointer increment-with-wrap is a local function,
//    used for both head and tail.
//  - Storage is a flat unpacked array of ISSUE_QUEUE_ELEMENT, written only on enq_fire.
// TESTING
//  1. Reset, then idle 3 cycles
//     -> enq_ready=1, deq_valid=0, count=0, deq_elem=0.
//  2. Enqueue 3 ADDIU elements (num2=1,2,3) back-to-back with deq_ready=0
//     -> count=3.
//     Then assert deq_ready -> deq_elem.num2 = 1,2,3 on consecutive cycles; count returns to 0.
//  3. Fill DEPTH=8 entries
//     -> enq_ready=0, count=8.
//     Assert enq_valid+deq_ready together -> one dequeue only, count=7.
//     Next cycle enq accepted -> count stays 7 under continuous enq+deq.
//  4. Stream 20 entries with deq_ready toggling every cycle
//     -> order preserved across head/tail wrap; no loss, no duplicate.
//  5. With 5 entries queued, assert flush together with enq_valid and deq_ready
//     -> deq_valid=0 that cycle; next cycle count=0, deq_valid=0; flushed enqueue absent.
//  6. rst and flush asserted together with 4 entries queued -> reset values next cycle.
//     Repeat test 2 with DEPTH=5 -> wrap at 4->0 correct.

Source files
------------

// File: rtl/issue_queue_fifo_pkg.sv
// Shared types for the decode -> execute issue path.
//   ISSUE_QUEUE_ELEMENT : one decoded instruction as handed from decoder to execute
//   ISSUE_QUEUE_DEPTH   : default queue depth used when instantiating issue_queue_fifo
package issue_queue_fifo_pkg;

  localparam int ISSUE_QUEUE_DEPTH = 8;

  typedef enum logic [5:0] {
    NOP   = 6'd0,
    ADDU  = 6'd1,
    ADDIU = 6'd2,
    SUBU  = 6'd3,
    LW    = 6'd4,
    SW    = 6'd5,
    BEQ   = 6'd6,
    BNE   = 6'd7,
    J     = 6'd8,
    JAL   = 6'd9
  } issue_op_e;

  typedef struct packed {
    issue_op_e   op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] num1;                  // first operand / immediate source
    logic [31:0] num2;                  // second operand / immediate
    logic [31:0] pc;
    logic [31:0] predict_pc_addr;       // front-end predicted next PC
    logic        predict_brunch_taken;  // front-end predicted direction
  } ISSUE_QUEUE_ELEMENT;

endpackage

// File: rtl/issue_queue_fifo.sv
// In-order issue queue between decoder and execute stage.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              discard all buffered entries this cycle (redirect)
//   enq_valid/ready    decoder-side handshake, enq_elem is the payload
//   deq_valid/ready    execute-side handshake, deq_elem is the oldest entry
//   count              number of buffered entries, 0..DEPTH
// An entry written in cycle N appears at the output in cycle N+1; the output
// is always read from storage, never bypassed from enq_elem.
module issue_queue_fifo
  import issue_queue_fifo_pkg::*;
#(
  parameter int  DEPTH = ISSUE_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  ISSUE_QUEUE_ELEMENT enq_elem,
  output logic               deq_valid,
  input  logic               deq_ready,
  output ISSUE_QUEUE_ELEMENT deq_elem,
  output logic [PTR_W:0]     count
);

  localparam int CNT_W = PTR_W + 1;

  // Increment with wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  ISSUE_QUEUE_ELEMENT mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq_fire, deq_fire;

  // enq_ready depends only on registered state, so a full queue refuses a
  // new entry even if the execute stage drains one in the same cycle.
  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign deq_valid = (count_q != '0) & ~flush;
  assign deq_elem  = (count_q != '0) ? mem[head_q] : '0;
  assign count     = count_q;

  assign enq_fire = enq_valid & enq_ready & ~flush;
  assign deq_fire = deq_valid & deq_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_fire) tail_d = ptr_inc(tail_q);
    if (deq_fire) head_d = ptr_inc(head_q);
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Flush overrides any handshake in the same cycle.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only slots between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[tail_q] <= enq_elem;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert (!(enq_fire && count_q == CNT_W'(DEPTH)));
      assert (!(deq_fire && count_q == '0));
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_fifo.sv
module tb_issue_queue_fifo;
  import issue_queue_fifo_pkg::*;

  logic               clk;
  logic               rst, flush;
  logic               enq_valid, enq_ready, deq_valid, deq_ready;
  ISSUE_QUEUE_ELEMENT enq_elem, deq_elem;
  logic [3:0]         count;

  logic               enq_valid5, enq_ready5, deq_valid5, deq_ready5;
  ISSUE_QUEUE_ELEMENT enq_elem5, deq_elem5;
  logic [3:0]         count5;

  int total, bad;

  issue_queue_fifo #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_elem(enq_elem),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_elem(deq_elem),
    .count(count)
  );

  issue_queue_fifo #(.DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid5), .enq_ready(enq_ready5), .enq_elem(enq_elem5),
    .deq_valid(deq_valid5), .deq_ready(deq_ready5), .deq_elem(deq_elem5),
    .count(count5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ISSUE_QUEUE_ELEMENT mk(input int n);
    ISSUE_QUEUE_ELEMENT e;
    e = '0;
    e.op = ADDIU;
    e.rs = 5'd1;
    e.rd = 5'd2;
    e.num1 = 32'h10;
    e.num2 = 32'(n);
    e.pc = 32'h0040_0000 + 32'(n) * 4;
    e.predict_pc_addr = 32'h8000_0000 + 32'(n) * 4;
    e.predict_brunch_taken = n[0];
    return e;
  endfunction

  task automatic test_reset;
    rst = 1; flush = 0;
    enq_valid = 0; deq_ready = 0; enq_elem = '0;
    enq_valid5 = 0; deq_ready5 = 0; enq_elem5 = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (deq_elem !== '0) begin bad++; $display("FAIL reset_deq_elem: got %h want 0", deq_elem); end
    total++; if (count5 !== 4'd0 || enq_ready5 !== 1'b1) begin bad++; $display("FAIL reset_d5: got count=%0d rdy=%b want 0/1", count5, enq_ready5); end
  endtask

  task automatic test_basic;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      enq_valid = 1; enq_elem = mk(i);
      #1;
      if (i == 1) begin
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL no_fallthrough: got %b want 0", deq_valid); end
      end
      if (i == 2) begin
        total++; if (deq_valid !== 1'b1 || deq_elem !== mk(1)) begin bad++; $display("FAIL latency_n1: got v=%b %h want 1 %h", deq_valid, deq_elem, mk(1)); end
      end
    end
    @(negedge clk);
    enq_valid = 0; deq_ready = 1;
    #1;
    total++; if (count !== 4'd3) begin bad++; $display("FAIL basic_count3: got %0d want 3", count); end
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) begin @(negedge clk); #1; end
      total++; if (deq_valid !== 1'b1 || deq_elem !== mk(i)) begin bad++; $display("FAIL basic_deq%0d: got v=%b %h want 1 %h", i, deq_valid, deq_elem, mk(i)); end
    end
    @(negedge clk);
    deq_ready = 0;
    #1;
    total++; if (count !== 4'd0 || deq_valid !== 1'b0) begin bad++; $display("FAIL basic_drained: got count=%0d v=%b want 0 0", count, deq_valid); end
  endtask

  task automatic test_full;
    int exp_n [7] = '{14, 15, 16, 17, 50, 51, 52};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      enq_valid = 1; enq_elem = mk(10 + i);
    end
    @(negedge clk);
    enq_elem = mk(50); deq_ready = 1;
    #1;
    total++; if (enq_ready !== 1'b0 || count !== 4'd8) begin bad++; $display("FAIL full_state: got rdy=%b count=%0d want 0 8", enq_ready, count); end
    total++; if (deq_elem !== mk(10)) begin bad++; $display("FAIL full_head: got %h want %h", deq_elem, mk(10)); end
    @(negedge clk);
    #1;
    total++; if (count !== 4'd7 || enq_ready !== 1'b1 || deq_elem.num2 !== 32'd11) begin bad++; $display("FAIL full_one_deq: got count=%0d rdy=%b num2=%0d want 7 1 11", count, enq_ready, deq_elem.num2); end
    @(negedge clk);
    enq_elem = mk(51);
    #1;
    total++; if (count !== 4'd7 || deq_elem.num2 !== 32'd12) begin bad++; $display("FAIL full_stream1: got count=%0d num2=%0d want 7 12", count, deq_elem.num2); end
    @(negedge clk);
    enq_elem = mk(52);
    #1;
    total++; if (count !== 4'd7 || deq_elem.num2 !== 32'd13) begin bad++; $display("FAIL full_stream2: got count=%0d num2=%0d want 7 13", count, deq_elem.num2); end
    @(negedge clk);
    enq_valid = 0;
    #1;
    total++; if (count !== 4'd7) begin bad++; $display("FAIL full_stream3: got count=%0d want 7", count); end
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      total++; if (deq_elem !== mk(exp_n[k])) begin bad++; $display("FAIL full_drain%0d: got %h want %h", k, deq_elem, mk(exp_n[k])); end
    end
    @(negedge clk);
    deq_ready = 0;
    #1;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL full_empty: got %0d want 0", count); end
  endtask

  task automatic test_stream;
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 20 && cyc < 200) begin
      @(negedge clk);
      deq_ready = cyc[0];
      enq_valid = (sent < 20);
      enq_elem  = mk(100 + sent);
      #1;
      if (deq_valid && deq_ready) begin
        total++; if (deq_elem !== mk(100 + rcvd)) begin bad++; $display("FAIL stream_order%0d: got %h want %h", rcvd, deq_elem, mk(100 + rcvd)); end
        rcvd++;
      end
      if (enq_valid && enq_ready) sent++;
      cyc++;
    end
    total++; if (rcvd != 20) begin bad++; $display("FAIL stream_timeout: got %0d received want 20", rcvd); end
    @(negedge clk);
    enq_valid = 0; deq_ready = 0;
    #1;
    total++; if (count !== 4'd0 || deq_valid !== 1'b0) begin bad++; $display("FAIL stream_empty: got count=%0d v=%b want 0 0", count, deq_valid); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      enq_valid = 1; enq_elem = mk(200 + i);
    end
    @(negedge clk);
    flush = 1; enq_elem = mk(77); deq_ready = 1;
    #1;
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL flush_deq_valid: got %b want 0", deq_valid); end
    @(negedge clk);
    flush = 0; enq_valid = 0; deq_ready = 0;
    #1;
    total++; if (count !== 4'd0 || deq_valid !== 1'b0 || deq_elem !== '0) begin bad++; $display("FAIL flush_after: got count=%0d v=%b elem=%h want 0 0 0", count, deq_valid, deq_elem); end
    @(negedge clk);
    enq_valid = 1; enq_elem = mk(300);
    @(negedge clk);
    enq_valid = 0;
    #1;
    total++; if (count !== 4'd1 || deq_elem !== mk(300)) begin bad++; $display("FAIL flush_dropped: got count=%0d %h want 1 %h", count, deq_elem, mk(300)); end
    deq_ready = 1;
    @(negedge clk);
    deq_ready = 0;
  endtask

  task automatic test_rst_flush;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      enq_valid = 1; enq_elem = mk(400 + i);
    end
    @(negedge clk);
    enq_valid = 0; rst = 1; flush = 1;
    @(negedge clk);
    rst = 0; flush = 0;
    #1;
    total++; if (count !== 4'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1 || deq_elem !== '0) begin bad++; $display("FAIL rst_flush: got count=%0d v=%b rdy=%b elem=%h want 0 0 1 0", count, deq_valid, enq_ready, deq_elem); end
  endtask

  task automatic test_depth5;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        enq_valid5 = 1; enq_elem5 = mk(1 + 3 * r + i);
      end
      @(negedge clk);
      enq_valid5 = 0; deq_ready5 = 1;
      for (int i = 0; i < 3; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        total++; if (deq_valid5 !== 1'b1 || deq_elem5 !== mk(1 + 3 * r + i)) begin bad++; $display("FAIL d5_round%0d_%0d: got v=%b %h want 1 %h", r, i, deq_valid5, deq_elem5, mk(1 + 3 * r + i)); end
      end
      @(negedge clk);
      deq_ready5 = 0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      enq_valid5 = 1; enq_elem5 = mk(7 + i);
    end
    @(negedge clk);
    enq_valid5 = 0;
    #1;
    total++; if (enq_ready5 !== 1'b0 || count5 !== 4'd5) begin bad++; $display("FAIL d5_full: got rdy=%b count=%0d want 0 5", enq_ready5, count5); end
    deq_ready5 = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      total++; if (deq_elem5 !== mk(7 + i)) begin bad++; $display("FAIL d5_drain%0d: got %h want %h", i, deq_elem5, mk(7 + i)); end
    end
    @(negedge clk);
    deq_ready5 = 0;
    #1;
    total++; if (count5 !== 4'd0) begin bad++; $display("FAIL d5_empty: got %0d want 0", count5); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_basic();
    test_full();
    test_stream();
    test_flush();
    test_rst_flush();
    test_depth5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
